conv_result_drain: RTL
======================

// Module: conv_result_drain
// PURPOSE
// - Output end of the convolution path: the reader for what SYS_ARRAY writes. Snapshots the
//   flattened SYS_ARRAY result bus on the rising edge of end_sig and streams it out one signed
//   16-bit word per transfer, row-major, over a valid/ready handshake.
// - Sits between SYS_ARRAY (result, end_sig) and the downstream consumer (pooling, writeback, bench).
// PARAMETERS
// - SIZE    9   padded image edge (IMG + 2*PAD); must match the SYS_ARRAY instance.
// - DW      16  word width, signed two's complement.
// - RELU    0   1 = clamp negative words to 0 on output; 0 = pass through unchanged.
// - OUT_DIM     localparam = SIZE-2; N = OUT_DIM*OUT_DIM words per frame.
// PORTS
// - clk        in   1             single clock; all logic on posedge.
// - rst        in   1             synchronous, active-high reset.
// - end_sig    in   1             SYS_ARRAY frame-complete level; only its rising edge is used.
// - result     in   [0:N*DW-1]    flattened frame; word k = result[k*DW +: DW], k = row*OUT_DIM+col.
// - out_data   out  DW            current word, signed.
// - out_valid  out  1             out_data/out_row/out_col/out_last valid.
// - out_ready  in   1             consumer accepts; transfer = out_valid & out_ready.
// - out_last   out  1             high with word N-1 only.
// - out_row    out  6             row index of current word.
// - out_col    out  6             column index of current word.
// - busy       out  1             frame captured and not yet fully drained.
// - overrun    out  1             sticky: end_sig rose while busy; cleared only by rst.
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; counters 0; end_sig edge register 0; snapshot regs undefined.
// - Edge detect: end_q <= end_sig each cycle; start = end_sig & ~end_q. A level held high
//   produces exactly one start; end_sig high during rst does not start (end_q updates in reset).
// - FSM IDLE: on start, copy result into snapshot regs, row=col=0, go STREAM; busy=1 next cycle.
// - FSM STREAM: out_valid=1; out_data=word(row,col) (ReLU applied if RELU=1: word<0 -> 0).
//   Latency: start in cycle T -> first out_valid in cycle T+1, combinationally from registers.
//   While out_valid & ~out_ready, all out_* held stable (no change, no drop).
//   On transfer: col+1; col wraps OUT_DIM-1 -> 0 with row+1. On transfer of word N-1
//   (out_last=1): go IDLE, out_valid=0 and busy=0 next cycle.
// - Throughput: one word per cycle with out_ready held high; N words in N cycles.
// - Back-to-back: start in the same cycle as the last transfer counts as busy -> overrun set,
//   frame dropped. First accepted start after return to IDLE begins a new frame.
// - Overrun: start while busy is ignored (snapshot unchanged, stream continues), overrun <= 1.
// - rst mid-frame: stream aborted immediately, outputs to reset values, overrun cleared.
// - out_row/out_col only meaningful while out_valid; held at last values otherwise is not
//   required -- reset to 0 on return to IDLE.
// - No arithmetic beyond indexing; no width growth; word taken bit-exact from result.
// STRUCTURE
// - Shared package cnn_pkg: DW, drain_state_t enum {IDLE, STREAM}, and function
//   out_dim(SIZE)=SIZE-2 so INPUT/SYS_ARRAY/drain agree on geometry.
// - One sub-module: rise_detect (end_sig -> start pulse). Snapshot as one N*DW register;
//   word select by index k = row*OUT_DIM+col (mux), counters row/col in 6 bits.
// TESTING (SIZE=9 -> 7x7, N=49, DW=16)
// - result word k = 3k, pulse end_sig 1 cycle, out_ready=1 -> 49 words 0,3,...,144 on
//   consecutive cycles, first one cycle after edge; out_last only on 144 at row=6,col=6.
// - Same frame, out_ready toggled 1,0,0,1 pattern -> same 49-word sequence, each word stable
//   across stall cycles, no duplicates or gaps.
// - RELU=1, word k = k-24 -> outputs 0 for k=0..24, then 1..24; RELU=0 -> -24..24 exact.
// - Change result bus to all 0xFFFF after capture -> stream still emits snapshot values.
// - Second end_sig edge at word 10 -> overrun=1, stream completes with original 49 words;
//   end_sig held high 100 cycles -> only one frame.
// - rst asserted at word 20 -> next cycle out_valid=0, busy=0, overrun=0; new edge restarts at word 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared geometry and types for the convolution path
package cnn_pkg;

  localparam int DW = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;

  // Valid-convolution output edge for a padded image of the given size
  function automatic int out_dim(input int size);
    return size - 2;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-cycle pulse on the rising edge of a level input
module rise_detect (
  input  logic clk,
  input  logic din,
  output logic pulse
);

  logic din_q;

  // Tracks the level even while the rest of the block is in reset, so a level
  // already high when reset releases is not mistaken for a new edge.
  always_ff @(posedge clk) begin
    din_q <= din;
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/conv_result_drain.sv
// rtl/conv_result_drain.sv - snapshots a finished conv frame and streams it out
// one signed word per valid/ready transfer, row-major.
module conv_result_drain
  import cnn_pkg::*;
#(
  parameter int SIZE = 9,
  parameter int DW = cnn_pkg::DW,
  parameter bit RELU = 1'b0,
  localparam int OUT_DIM = out_dim(SIZE),
  localparam int N = OUT_DIM * OUT_DIM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 end_sig,
  input  logic [0:N*DW-1]      result,
  output logic signed [DW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [5:0]           out_row,
  output logic [5:0]           out_col,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [5:0] LAST_IDX = 6'(OUT_DIM - 1);

  drain_state_t         state;
  drain_state_t         state_nxt;
  logic                 start;
  logic                 xfer;
  logic                 col_end;
  logic                 at_last;
  logic [5:0]           row;
  logic [5:0]           col;
  logic [0:N*DW-1]      snap;
  int unsigned          k;
  logic signed [DW-1:0] word;

  rise_detect u_rise (
    .clk   (clk),
    .din   (end_sig),
    .pulse (start)
  );

  assign col_end = (col == LAST_IDX);
  assign at_last = col_end && (row == LAST_IDX);
  assign xfer    = (state == STREAM) && out_ready;
  assign k       = int'(row) * OUT_DIM + int'(col);
  assign word    = snap[k*DW +: DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (xfer && at_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    if (state == STREAM) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_last  = at_last;
      out_data  = (RELU && word[DW-1]) ? '0 : word;
    end
  end

  assign out_row = row;
  assign out_col = col;

  // The snapshot is only ever read while streaming, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      snap <= result;
    end
  end

  // A start that lands while streaming (including on the final transfer) is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      overrun <= 1'b0;
    end else begin
      if (start && state == STREAM) overrun <= 1'b1;
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
      end else if (xfer) begin
        if (at_last) begin
          row <= '0;
          col <= '0;
        end else if (col_end) begin
          row <= row + 6'd1;
          col <= '0;
        end else begin
          col <= col + 6'd1;
        end
      end
    end
  end

endmodule
